// File: rtl/pipe_hazard_ctrl.sv
// Purpose: central stall/flush scheduler that merges the load-use, multi-cycle EX and exception sources into one freeze vector.
// Latency: stall is same-cycle combinational; flush/new_pc/ex_cancel/ex_timeout appear one cycle after the deciding cycle.
// Backpressure: none accepted; the freeze vector itself is the backpressure this block applies to the pipeline.
module pipe_hazard_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter int                TIMEOUT_CYC = 64,
  parameter logic [ADDR_W-1:0] TO_VECTOR   = 32'hBFC0_0380,
  parameter int                CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req_id,
  input  logic              ex_start,
  input  logic              ex_done,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_addr,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              ex_cancel,
  output logic              ex_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int WC_W = $clog2(TIMEOUT_CYC);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT_CYC - 1);

  // Freeze patterns: everything, front end up to EX, front end up to ID.
  localparam logic [5:0] STALL_ALL = 6'b111111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_ID  = 6'b000111;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT_EX,
    S_FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] new_pc_q, new_pc_d;
  logic              flush_q, flush_d;
  logic              ex_cancel_q, ex_cancel_d;
  logic              ex_timeout_q, ex_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [5:0]        stall_c;

  // Next-state, freeze vector and registered-pulse decisions from state and requests.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    new_pc_d     = new_pc_q;
    flush_d      = 1'b0;
    ex_cancel_d  = 1'b0;
    ex_timeout_d = 1'b0;
    stall_c      = '0;
    case (state_q)
      S_RUN: begin
        if (exc_req) begin
          stall_c  = STALL_ALL;
          new_pc_d = exc_addr;
          flush_d  = 1'b1;
          state_d  = S_FLUSH;
        end else if (ex_start && !ex_done) begin
          stall_c    = STALL_EX;
          wait_cnt_d = '0;
          state_d    = S_WAIT_EX;
        end else if (ex_start) begin
          // Zero-wait op: result arrives with the issue, nothing to hold.
          stall_c = '0;
        end else if (stall_req_id) begin
          stall_c = STALL_ID;
        end
      end
      S_WAIT_EX: begin
        if (exc_req) begin
          stall_c     = STALL_ALL;
          new_pc_d    = exc_addr;
          flush_d     = 1'b1;
          ex_cancel_d = 1'b1;
          state_d     = S_FLUSH;
        end else if (ex_done) begin
          // Done wins over a coincident watchdog expiry.
          state_d = S_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          stall_c      = STALL_ALL;
          new_pc_d     = TO_VECTOR;
          flush_d      = 1'b1;
          ex_cancel_d  = 1'b1;
          ex_timeout_d = 1'b1;
          state_d      = S_FLUSH;
        end else begin
          stall_c    = STALL_EX;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        // Single redirect cycle; a still-pending exception is retaken from RUN.
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Freeze vector is forced idle while reset is held so nothing moves during reset.
  always_comb begin
    stall = rst ? stall_c : 6'b0;
  end

  // Saturating count of frozen cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall != 6'b0) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RUN;
      wait_cnt_q   <= '0;
      new_pc_q     <= '0;
      flush_q      <= 1'b0;
      ex_cancel_q  <= 1'b0;
      ex_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      new_pc_q     <= new_pc_d;
      flush_q      <= flush_d;
      ex_cancel_q  <= ex_cancel_d;
      ex_timeout_q <= ex_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign flush      = flush_q;
  assign new_pc     = new_pc_q;
  assign ex_cancel  = ex_cancel_q;
  assign ex_timeout = ex_timeout_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an 8-cycle watchdog.
// Inputs change on the falling edge; outputs are sampled 1ns later, before the next rising edge.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_req_id;
  logic        ex_start;
  logic        ex_done;
  logic        exc_req;
  logic [31:0] exc_addr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_cancel;
  logic        ex_timeout;
  logic [31:0] stall_cnt;

  int n_chk;
  int n_err;

  pipe_hazard_ctrl #(
    .ADDR_W      (32),
    .TIMEOUT_CYC (8),
    .TO_VECTOR   (32'hBFC0_0380),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req_id (stall_req_id),
    .ex_start     (ex_start),
    .ex_done      (ex_done),
    .exc_req      (exc_req),
    .exc_addr     (exc_addr),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .ex_cancel    (ex_cancel),
    .ex_timeout   (ex_timeout),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs on the falling edge, then settle.
  task automatic cyc(input logic sid, input logic es, input logic ed,
                     input logic er, input logic [31:0] ea);
    @(negedge clk);
    stall_req_id = sid;
    ex_start     = es;
    ex_done      = ed;
    exc_req      = er;
    exc_addr     = ea;
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    stall_req_id = 1'b1;
    ex_start     = 1'b0;
    ex_done      = 1'b0;
    exc_req      = 1'b1;
    exc_addr     = 32'h0;
    #2;
    // Requests held during reset must not freeze anything.
    check("rst_stall", stall, 6'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_newpc", new_pc, 32'h0);
    check("rst_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    stall_req_id = 1'b0;
    exc_req      = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Idle
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 32'h0);
      check("idle_stall", stall, 6'b0);
    end
    check("idle_flush", flush, 1'b0);
    check("idle_cnt", stall_cnt, 32'd0);

    // Load-use for two cycles
    cyc(1, 0, 0, 0, 32'h0);
    check("lu_stall0", stall, 6'b000111);
    cyc(1, 0, 0, 0, 32'h0);
    check("lu_stall1", stall, 6'b000111);
    cyc(0, 0, 0, 0, 32'h0);
    check("lu_release", stall, 6'b0);
    check("lu_cnt", stall_cnt, 32'd2);

    // Multi-cycle op with done at t0+5; load-use coincident with start
    cyc(1, 1, 0, 0, 32'h0);
    check("mc_t0", stall, 6'b001111);
    for (int i = 1; i < 5; i++) begin
      cyc(1, 0, 0, 0, 32'h0);
      check("mc_wait", stall, 6'b001111);
    end
    cyc(0, 0, 1, 0, 32'h0);
    check("mc_done", stall, 6'b0);
    cyc(0, 0, 0, 0, 32'h0);
    check("mc_after", stall, 6'b0);
    check("mc_flush", flush, 1'b0);
    check("mc_cnt", stall_cnt, 32'd7);

    // Zero-wait op and stray done in RUN
    cyc(1, 1, 1, 0, 32'h0);
    check("zw_stall", stall, 6'b0);
    cyc(0, 0, 1, 0, 32'h0);
    check("done_run_stall", stall, 6'b0);
    check("zw_cnt", stall_cnt, 32'd7);

    // Watchdog expiry
    cyc(0, 1, 0, 0, 32'h0);
    check("to_t0", stall, 6'b001111);
    for (int i = 1; i < 8; i++) begin
      cyc(0, 0, 0, 0, 32'h0);
      check("to_wait", stall, 6'b001111);
    end
    cyc(0, 0, 0, 0, 32'h0);
    check("to_fire_stall", stall, 6'b111111);
    check("to_fire_flush", flush, 1'b0);
    cyc(0, 0, 0, 0, 32'h0);
    check("to_flush", flush, 1'b1);
    check("to_timeout", ex_timeout, 1'b1);
    check("to_cancel", ex_cancel, 1'b1);
    check("to_newpc", new_pc, 32'hBFC0_0380);
    check("to_flush_stall", stall, 6'b0);
    cyc(0, 0, 0, 0, 32'h0);
    check("to_run_flush", flush, 1'b0);
    check("to_run_timeout", ex_timeout, 1'b0);
    check("to_run_stall", stall, 6'b0);
    check("to_cnt", stall_cnt, 32'd16);

    // Exception during WAIT_EX, held high through the flush cycle
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    check("exw_wait", stall, 6'b001111);
    cyc(0, 0, 0, 1, 32'h8000_0180);
    check("exw_stall", stall, 6'b111111);
    cyc(0, 0, 0, 1, 32'h0000_0000);
    check("exw_flush", flush, 1'b1);
    check("exw_newpc", new_pc, 32'h8000_0180);
    check("exw_cancel", ex_cancel, 1'b1);
    check("exw_timeout", ex_timeout, 1'b0);
    check("exw_flush_stall", stall, 6'b0);
    cyc(0, 0, 0, 0, 32'h0);
    check("exw_run_flush", flush, 1'b0);
    check("exw_run_cancel", ex_cancel, 1'b0);
    check("exw_cnt", stall_cnt, 32'd20);

    // Exception from RUN: no cancel
    cyc(1, 1, 0, 1, 32'h0000_1234);
    check("exr_stall", stall, 6'b111111);
    cyc(0, 0, 0, 0, 32'h0);
    check("exr_flush", flush, 1'b1);
    check("exr_newpc", new_pc, 32'h0000_1234);
    check("exr_cancel", ex_cancel, 1'b0);
    check("exr_cnt", stall_cnt, 32'd21);

    // Done coincident with the watchdog cycle
    cyc(0, 1, 0, 0, 32'h0);
    for (int i = 1; i < 8; i++) begin
      cyc(0, 0, 0, 0, 32'h0);
    end
    check("dt_wait", stall, 6'b001111);
    cyc(0, 0, 1, 0, 32'h0);
    check("dt_stall", stall, 6'b0);
    cyc(0, 0, 0, 0, 32'h0);
    check("dt_flush", flush, 1'b0);
    check("dt_timeout", ex_timeout, 1'b0);
    check("dt_cnt", stall_cnt, 32'd29);

    // Reset mid-WAIT_EX
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    check("rw_wait", stall, 6'b001111);
    rst = 1'b0;
    #1;
    check("rw_stall", stall, 6'b0);
    check("rw_cnt", stall_cnt, 32'd0);
    check("rw_cancel", ex_cancel, 1'b0);
    check("rw_flush", flush, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 1, 0, 32'h0);
    check("rw_done_stall", stall, 6'b0);
    cyc(1, 0, 0, 0, 32'h0);
    check("rw_run_state", stall, 6'b000111);
    check("rw_run_cancel", ex_cancel, 1'b0);
    check("rw_run_flush", flush, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
